// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file: round-robin between the integer and FPU
// result paths, plus a scoreboard of pending FPU destinations that drives decode stall.
module regfile_wb_arbiter #(
    parameter int V = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         int_valid,
    output logic         int_ready,
    input  logic [4:0]   int_rd,
    input  logic [V-1:0] int_data,
    input  logic         fp_valid,
    output logic         fp_ready,
    input  logic [4:0]   fp_rd,
    input  logic [V-1:0] fp_data,
    input  logic         issue_valid,
    input  logic [4:0]   issue_rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    output logic         stall,
    output logic         Reg_write,
    output logic [4:0]   wr_adder,
    output logic [V-1:0] wr_data,
    output logic [31:0]  busy_vec,
    output logic         waw_err
);

    // last_fp: FPU won the most recent contested cycle, so integer has priority next
    logic        last_fp;
    logic        int_hs, fp_hs, contested;
    logic [31:0] busy_nxt;

    assign int_ready = !rst && int_valid && (!fp_valid || last_fp);
    assign fp_ready  = !rst && fp_valid && (!int_valid || !last_fp);
    assign int_hs    = int_valid && int_ready;
    assign fp_hs     = fp_valid && fp_ready;
    assign contested = !rst && int_valid && fp_valid;

    assign stall = (rs1 != 5'd0 && busy_vec[rs1]) ||
                   (rs2 != 5'd0 && busy_vec[rs2]) ||
                   (issue_valid && issue_rd != 5'd0 && busy_vec[issue_rd]);

    // Clear first so an issue to the same index in the same cycle keeps it busy
    always_comb begin
        busy_nxt = busy_vec;
        if (fp_hs)
            busy_nxt[fp_rd] = 1'b0;
        if (issue_valid && issue_rd != 5'd0)
            busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Reg_write <= 1'b0;
            wr_adder  <= '0;
            wr_data   <= '0;
            busy_vec  <= '0;
            waw_err   <= 1'b0;
            last_fp   <= 1'b1;
        end else begin
            busy_vec <= busy_nxt;
            if (contested)
                last_fp <= fp_hs;
            if (int_hs) begin
                Reg_write <= (int_rd != 5'd0);
                wr_adder  <= int_rd;
                wr_data   <= int_data;
            end else if (fp_hs) begin
                Reg_write <= (fp_rd != 5'd0);
                wr_adder  <= fp_rd;
                wr_data   <= fp_data;
            end else begin
                Reg_write <= 1'b0;
            end
            if (int_hs && int_rd != 5'd0 && busy_vec[int_rd])
                waw_err <= 1'b1;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: V, default 32, data width of register file write data.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 int_valid / int_ready  in / out  1 / 1  integer writeback handshake (ALU, load path).
REQ-005 int_rd / int_data  in  5 / V  integer destination register index and result.
REQ-006 fp_valid / fp_ready  in / out  1 / 1  FPU writeback handshake.
REQ-007 fp_rd / fp_data  in  5 / V  FPU destination register index and result.
REQ-008 issue_valid / issue_rd  in  1 / 5  FPU op issued; marks issue_rd pending.
REQ-009 rs1 / rs2  in  5 / 5  source indices of the instruction in decode.
REQ-010 stall  out  1  decode hazard, combinational from registered state.
REQ-011 Reg_write / wr_adder / wr_data  out  1 / 5 / V  registered write port driving the register file.
REQ-012 busy_vec  out  32  scoreboard, bit n set = xn has a pending FPU result.
REQ-013 waw_err  out  1  sticky protocol-error flag.

Function
REQ-014 Handshake SHALL be valid&ready in the same cycle; ready is combinational from the valids and the last_fp flag; requesters hold rd/data stable while valid and not ready.
REQ-015 Only one requester SHALL be granted per cycle; sole valid requester is always granted (ready=1 in that cycle).
REQ-016 When both are valid, the requester not granted in the most recent contested cycle SHALL win (round robin); last_fp updates only on contested cycles.
REQ-017 Uncontested grants SHALL NOT change last_fp.
REQ-018 Accepted write SHALL appear at the write port exactly 1 cycle after handshake: Reg_write=1, wr_adder=rd, wr_data=data.
REQ-019 Accepted write with rd=0 SHALL complete the handshake but drive Reg_write=0.
REQ-020 In cycles with no handshake Reg_write SHALL be 0; wr_adder/wr_data hold last values.
REQ-021 issue_valid with issue_rd!=0 SHALL set busy_vec[issue_rd] at the next edge; issue_rd=0 is ignored.
REQ-022 FPU handshake SHALL clear busy_vec[fp_rd] at the next edge (same edge the write is registered).
REQ-023 Set and clear of the same index in one cycle: set SHALL win.
REQ-024 stall = (rs1!=0 & busy_vec[rs1]) | (rs2!=0 & busy_vec[rs2]) | (issue_valid & issue_rd!=0 & busy_vec[issue_rd]).
REQ-025 stall SHALL use registered busy_vec only; it deasserts the cycle the pending write is presented on the write port.
REQ-026 Integer handshake with int_rd!=0 and busy_vec[int_rd]=1 SHALL set waw_err at the next edge; the write still proceeds and busy is unchanged.
REQ-027 waw_err SHALL stay set until rst.
REQ-028 Issue to an already-busy index SHALL leave it busy (single bit, no count).

Reset
REQ-029 On rst assertion, immediately: Reg_write=0, wr_adder=0, wr_data=0, busy_vec=0, waw_err=0, last_fp=1 (integer wins first contest).
REQ-030 A handshake coinciding with rst SHALL be discarded; no write emitted after release.
REQ-031 While rst is asserted, int_ready and fp_ready SHALL be 0.

Verification
REQ-032 int_valid=1, int_rd=5, int_data=0xA5A5A5A5, fp_valid=0 -> int_ready=1 same cycle; next cycle Reg_write=1, wr_adder=5, wr_data=0xA5A5A5A5.
REQ-033 Both valid for 3 cycles after reset (int_rd=1, fp_rd=2) -> grants int, fp, int; Reg_write=1 each following cycle with wr_adder 1,2,1.
REQ-034 issue_valid=1, issue_rd=7; next cycle rs1=7 -> busy_vec[7]=1, stall=1; fp handshake fp_rd=7 -> next cycle Reg_write=1, wr_adder=7, busy_vec[7]=0, stall=0.
REQ-035 Same cycle: issue_rd=9 and fp handshake fp_rd=9 with busy_vec[9]=1 -> busy_vec[9] remains 1.
REQ-036 busy_vec[3]=1, int handshake int_rd=3 -> write occurs to x3, waw_err=1 and stays 1; fp handshake rd=0 -> Reg_write=0.
REQ-037 rst asserted mid-cycle with busy_vec=0x00000090 and pending handshake -> busy_vec=0, Reg_write=0 immediately and no write after release.
